// File: rtl/kbd_tick_ctrl.sv
// Programmable keyboard timebase: one-cycle tick enable plus square-wave level,
// with start/stop/one-shot control and period changes applied only at period boundaries.
module kbd_tick_ctrl #(
   parameter int               WIDTH       = 24,
   parameter logic [WIDTH-1:0] DEFAULT_DIV = 24'h7FFFFF,
   parameter int               CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [WIDTH-1:0] cfg_div,
   input  logic             cmd_start,
   input  logic             cmd_oneshot,
   input  logic             cmd_stop,
   output logic             tick,
   output logic             kbd_level,
   output logic             busy,
   output logic             done,
   output logic             pend,
   output logic [CNT_W-1:0] tick_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      ONESHOT
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] div_active;
   logic [WIDTH-1:0] div_shadow;
   logic [WIDTH-1:0] counter;
   logic [WIDTH-1:0] div_next;
   logic             running;
   logic             terminal;
   logic             reload;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (cmd_stop)         next_state = IDLE;
            else if (cmd_start)   next_state = RUN;
            else if (cmd_oneshot) next_state = ONESHOT;
         end
         RUN: begin
            if (cmd_stop) next_state = IDLE;
         end
         ONESHOT: begin
            if (cmd_stop)       next_state = IDLE;
            else if (cmd_start) next_state = RUN;
            else if (terminal)  next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   // A fresh write beats any pending shadow value; in IDLE pend is always 0.
   always_comb begin
      running  = (state != IDLE);
      terminal = running && (counter == div_active);
      reload   = !running || cmd_stop || cmd_start || terminal;
      div_next = cfg_we ? cfg_div : (pend ? div_shadow : div_active);
   end

   // div_active only changes when the counter restarts, so counter never exceeds it.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_active <= DEFAULT_DIV;
         div_shadow <= DEFAULT_DIV;
         counter    <= '0;
         tick       <= 1'b0;
         kbd_level  <= 1'b0;
         done       <= 1'b0;
         pend       <= 1'b0;
         tick_cnt   <= '0;
      end else begin
         tick <= 1'b0;
         done <= 1'b0;
         if (reload) begin
            counter    <= '0;
            div_active <= div_next;
            pend       <= 1'b0;
            if (cmd_stop) begin
               kbd_level <= 1'b0;
            end else if (running && !cmd_start) begin
               tick      <= 1'b1;
               kbd_level <= ~kbd_level;
               tick_cnt  <= tick_cnt + CNT_W'(1);
               done      <= (state == ONESHOT);
            end
         end else begin
            counter <= counter + WIDTH'(1);
            if (cfg_we) begin
               div_shadow <= cfg_div;
               pend       <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/kbd_tick_ctrl.md
Name: kbd_tick_ctrl

Overview:
- Programmable scheduler for the keyboard timing resource: replaces the free-running divided keyboard clock with a controlled, reconfigurable timebase.
- Generates a one-cycle tick enable and a square-wave level in the main clock domain, so all keyboard logic stays single-clock.
- Supports start/stop/one-shot commands and glitch-free period changes at period boundaries.

Parameters:
- WIDTH, 24, width of divider and counter.
- DEFAULT_DIV, 24'h7FFFFF, divider value loaded at reset. Period = DEFAULT_DIV+1 cycles, giving a half-period of 2^23 cycles.
- CNT_W, 8, width of tick_cnt.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cfg_we  in  1  write cfg_div this cycle
- cfg_div  in  WIDTH  new divider value; period = cfg_div+1 cycles
- cmd_start  in  1  start or restart continuous running
- cmd_oneshot  in  1  run exactly one period, then stop
- cmd_stop  in  1  stop immediately
- tick  out  1  one-cycle pulse at each period end (registered)
- kbd_level  out  1  toggles at each tick (registered)
- busy  out  1  high in RUN or ONESHOT
- done  out  1  one-cycle pulse when ONESHOT completes
- pend  out  1  shadow divider waiting to be applied
- tick_cnt  out  CNT_W  ticks since reset; wraps modulo 2^CNT_W

Behaviour:
- Reset values: state IDLE; div_active=DEFAULT_DIV; div_shadow=DEFAULT_DIV; counter=0; tick=0; kbd_level=0; busy=0; done=0; pend=0; tick_cnt=0.
- States:
  - IDLE: counter held at 0.
  - RUN: continuous ticking.
  - ONESHOT: a single period.
- Command priority when several are asserted in one cycle: cmd_stop > cmd_start > cmd_oneshot.
- IDLE transitions:
  - cmd_start -> RUN.
  - cmd_oneshot -> ONESHOT.
  - On either, counter<=0 and busy=1 from the next cycle.
- RUN transitions:
  - cmd_stop -> IDLE.
  - cmd_start -> counter<=0, stays in RUN (resync); kbd_level is unchanged.
  - cmd_oneshot -> ignored.
- ONESHOT transitions:
  - cmd_stop -> IDLE with no done pulse.
  - cmd_start -> RUN with counter<=0.
- Terminal count: counter==div_active while in RUN or ONESHOT. At the next edge:
  - counter<=0, tick<=1, kbd_level toggles, tick_cnt increments.
  - tick is high for exactly that one cycle.
  - Latency from the start edge to the first tick is div_active+1 cycles.
  - Period is div_active+1 cycles.
  - div_active=0: tick is high every cycle while running; kbd_level toggles every cycle.
- ONESHOT terminal: the same tick is produced, plus done<=1 for one cycle, busy<=0, and state returns to IDLE.
- Stop:
  - Next cycle: IDLE, counter=0, kbd_level=0, busy=0.
  - Stop coinciding with terminal count: stop wins; no tick, no increment.
- Configuration writes:
  - cfg_we in IDLE: div_active<=cfg_div directly; pend stays 0.
  - cfg_we together with cmd_start or cmd_oneshot: the new value is used for that run.
  - cfg_we while busy, not at terminal: div_shadow<=cfg_div, pend<=1. Later writes overwrite div_shadow.
  - At terminal with pend=1: div_active<=div_shadow, pend<=0. The new period starts with the next count.
  - cfg_we in the same cycle as terminal: div_active<=cfg_div directly and pend<=0 (written value wins over the old shadow).
  - Stop while pend=1: div_active<=div_shadow, pend<=0.
- Counter never exceeds div_active. If a write causes counter>div_active, that is impossible by construction: div_active changes only with counter<=0 or in IDLE.
- Reset mid-operation returns all state to the reset values on the next edge, regardless of commands.

Test Plan:
- Reset, then cmd_start with DEFAULT_DIV overridden by cfg_div=3 in the same cycle -> tick on cycles 4, 8, 12 after start; kbd_level pattern 1,0,1 at those ticks; tick_cnt=3.
- div=1, running; cfg_we cfg_div=4 mid-period -> pend=1 until the next tick; subsequent ticks 5 cycles apart; pend=0 after the apply.
- div=2, cmd_oneshot -> single tick at cycle 3 with done=1 in the same cycle; busy=0 afterwards; no further ticks over 20 cycles.
- div=5 running; cmd_stop asserted exactly on the terminal cycle -> no tick, no tick_cnt increment; kbd_level=0; busy=0 next cycle.
- div=0 running 10 cycles -> tick high all 10 cycles; tick_cnt=10; then cmd_start and cmd_stop in the same cycle -> IDLE (stop priority).
- rst pulsed while RUN with pend=1 and tick_cnt=255 -> all outputs at reset values next cycle; div_active=DEFAULT_DIV; tick_cnt=0. Separately, wrap check: 256 ticks from 0 -> tick_cnt=0.
